// File: rtl/cpu_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, EX FSM states, datapath width.
package cpu_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_MUL  = 4'd9;
  localparam logic [3:0] ALU_DIVU = 4'd10;
  localparam logic [3:0] ALU_REMU = 4'd11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } ex_state_e;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative unsigned multiply / divide: shift-add multiplier and restoring divider
// sharing one iteration counter and one pair of working registers.
module ex_muldiv
  import cpu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int ITER = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(ITER);

  logic            busy_reg;
  logic [CW-1:0]   cnt_reg;
  logic [3:0]      op_reg;
  // hi: product accumulator / partial remainder; lo: multiplier / dividend->quotient
  logic [XLEN-1:0] hi_reg;
  logic [XLEN-1:0] lo_reg;
  logic [XLEN-1:0] b_reg;

  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;
  logic            last_iter;

  assign div_shift = {hi_reg, lo_reg[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, b_reg};
  assign last_iter = (cnt_reg == CW'(ITER - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_reg <= 1'b0;
      cnt_reg  <= '0;
      op_reg   <= '0;
      hi_reg   <= '0;
      lo_reg   <= '0;
      b_reg    <= '0;
    end else if (kill) begin
      busy_reg <= 1'b0;
      cnt_reg  <= '0;
    end else if (start) begin
      busy_reg <= 1'b1;
      cnt_reg  <= '0;
      op_reg   <= op;
      hi_reg   <= '0;
      if (op == ALU_MUL) begin
        lo_reg <= b;
        b_reg  <= a;
      end else begin
        lo_reg <= a;
        b_reg  <= b;
      end
    end else if (busy_reg) begin
      if (op_reg == ALU_MUL) begin
        hi_reg <= hi_reg + (lo_reg[0] ? b_reg : '0);
        b_reg  <= b_reg << 1;
        lo_reg <= lo_reg >> 1;
      end else begin
        // A zero divisor never borrows, giving all-ones quotient and remainder = dividend.
        hi_reg <= div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
        lo_reg <= {lo_reg[XLEN-2:0], ~div_diff[XLEN]};
      end
      cnt_reg <= cnt_reg + 1'b1;
      if (last_iter) begin
        busy_reg <= 1'b0;
      end
    end
  end

  assign busy   = busy_reg;
  assign done   = busy_reg && last_iter;
  assign result = (op_reg == ALU_DIVU) ? lo_reg : hi_reg;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID/EX pipeline register, single-cycle ALU and bubble/flush handling.
// Define EX_MULDIV_EN to add the iterative MUL/DIVU/REMU unit with its stall FSM.
module ex_stage
  import cpu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int ITER = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_EX_valid,
  input  logic            i_EX_flush,
  input  logic            i_EX_regWe,
  input  logic            i_EX_dMemWe,
  input  logic            i_EX_sWD,
  input  logic            i_EX_sALUsrc,
  input  logic [3:0]      i_EX_aluOp,
  input  logic [4:0]      i_EX_WRA,
  input  logic [XLEN-1:0] i_EX_rd1,
  input  logic [XLEN-1:0] i_EX_rd2,
  input  logic [XLEN-1:0] i_EX_imm,
  output logic            o_EX_regWe,
  output logic            o_EX_dMemWe,
  output logic            o_EX_sWD,
  output logic [4:0]      o_EX_WRA,
  output logic [XLEN-1:0] o_EX_aluOut,
  output logic [XLEN-1:0] o_EX_rd2,
  output logic            o_EX_stall
);

  localparam int SHW = $clog2(XLEN);

  logic            valid_reg;
  logic            regwe_reg;
  logic            dmemwe_reg;
  logic            swd_reg;
  logic            alusrc_reg;
  logic [3:0]      aluop_reg;
  logic [4:0]      wra_reg;
  logic [XLEN-1:0] rd1_reg;
  logic [XLEN-1:0] rd2_reg;
  logic [XLEN-1:0] imm_reg;

  logic            stall;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] ex_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst || i_EX_flush) begin
      valid_reg  <= 1'b0;
      regwe_reg  <= 1'b0;
      dmemwe_reg <= 1'b0;
      swd_reg    <= 1'b0;
      alusrc_reg <= 1'b0;
      aluop_reg  <= '0;
      wra_reg    <= '0;
      rd1_reg    <= '0;
      rd2_reg    <= '0;
      imm_reg    <= '0;
    end else if (!stall) begin
      valid_reg  <= i_EX_valid;
      regwe_reg  <= i_EX_regWe;
      dmemwe_reg <= i_EX_dMemWe;
      swd_reg    <= i_EX_sWD;
      alusrc_reg <= i_EX_sALUsrc;
      aluop_reg  <= i_EX_aluOp;
      wra_reg    <= i_EX_WRA;
      rd1_reg    <= i_EX_rd1;
      rd2_reg    <= i_EX_rd2;
      imm_reg    <= i_EX_imm;
    end
  end

  assign op_b = alusrc_reg ? imm_reg : rd2_reg;

  always_comb begin
    alu_res = '0;
    case (aluop_reg)
      ALU_ADD: alu_res = rd1_reg + op_b;
      ALU_SUB: alu_res = rd1_reg - op_b;
      ALU_AND: alu_res = rd1_reg & op_b;
      ALU_OR:  alu_res = rd1_reg | op_b;
      ALU_XOR: alu_res = rd1_reg ^ op_b;
      ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(rd1_reg) < $signed(op_b))};
      ALU_SLL: alu_res = rd1_reg << op_b[SHW-1:0];
      ALU_SRL: alu_res = rd1_reg >> op_b[SHW-1:0];
      ALU_SRA: alu_res = $unsigned($signed(rd1_reg) >>> op_b[SHW-1:0]);
      default: alu_res = '0;
    endcase
  end

`ifdef EX_MULDIV_EN
  ex_state_e       state_reg;
  ex_state_e       state_next;
  logic            md_start;
  logic            md_kill;
  logic            md_busy;
  logic            md_done;
  logic [XLEN-1:0] md_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    md_start   = 1'b0;
    md_kill    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (valid_reg && is_muldiv(aluop_reg)) begin
          stall = 1'b1;
          if (!i_EX_flush) begin
            md_start   = 1'b1;
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (i_EX_flush) begin
          md_kill    = 1'b1;
          state_next = IDLE;
        end else if (md_done) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  ex_muldiv #(
    .XLEN (XLEN),
    .ITER (ITER)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .kill   (md_kill),
    .op     (aluop_reg),
    .a      (rd1_reg),
    .b      (op_b),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  // md_busy mirrors the BUSY state; kept for visibility only.
  logic md_busy_unused;
  assign md_busy_unused = md_busy;

  assign ex_result = (state_reg == DONE) ? md_result : alu_res;
`else
  assign stall     = 1'b0;
  assign ex_result = alu_res;
`endif

  // While stalled, MEM sees a full bubble; an invalid slot can never write.
  assign o_EX_regWe  = !stall && valid_reg && regwe_reg;
  assign o_EX_dMemWe = !stall && valid_reg && dmemwe_reg;
  assign o_EX_sWD    = !stall && swd_reg;
  assign o_EX_WRA    = stall ? '0 : wra_reg;
  assign o_EX_aluOut = stall ? '0 : ex_result;
  assign o_EX_rd2    = rd2_reg;
  assign o_EX_stall  = stall;

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage; covers the mul/div path when EX_MULDIV_EN is defined.
module tb_ex_stage;
  import cpu_pkg::*;

  logic        clk;
  logic        rst;
  logic        i_EX_valid;
  logic        i_EX_flush;
  logic        i_EX_regWe;
  logic        i_EX_dMemWe;
  logic        i_EX_sWD;
  logic        i_EX_sALUsrc;
  logic [3:0]  i_EX_aluOp;
  logic [4:0]  i_EX_WRA;
  logic [31:0] i_EX_rd1;
  logic [31:0] i_EX_rd2;
  logic [31:0] i_EX_imm;
  logic        o_EX_regWe;
  logic        o_EX_dMemWe;
  logic        o_EX_sWD;
  logic [4:0]  o_EX_WRA;
  logic [31:0] o_EX_aluOut;
  logic [31:0] o_EX_rd2;
  logic        o_EX_stall;

  int checks = 0;
  int errors = 0;

  ex_stage #(.XLEN(32), .ITER(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_EX_valid   (i_EX_valid),
    .i_EX_flush   (i_EX_flush),
    .i_EX_regWe   (i_EX_regWe),
    .i_EX_dMemWe  (i_EX_dMemWe),
    .i_EX_sWD     (i_EX_sWD),
    .i_EX_sALUsrc (i_EX_sALUsrc),
    .i_EX_aluOp   (i_EX_aluOp),
    .i_EX_WRA     (i_EX_WRA),
    .i_EX_rd1     (i_EX_rd1),
    .i_EX_rd2     (i_EX_rd2),
    .i_EX_imm     (i_EX_imm),
    .o_EX_regWe   (o_EX_regWe),
    .o_EX_dMemWe  (o_EX_dMemWe),
    .o_EX_sWD     (o_EX_sWD),
    .o_EX_WRA     (o_EX_WRA),
    .o_EX_aluOut  (o_EX_aluOut),
    .o_EX_rd2     (o_EX_rd2),
    .o_EX_stall   (o_EX_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic valid, input logic [3:0] op, input logic [4:0] wra,
                       input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                       input logic alusrc, input logic regwe, input logic dmemwe, input logic swd);
    i_EX_valid   = valid;
    i_EX_aluOp   = op;
    i_EX_WRA     = wra;
    i_EX_rd1     = rd1;
    i_EX_rd2     = rd2;
    i_EX_imm     = imm;
    i_EX_sALUsrc = alusrc;
    i_EX_regWe   = regwe;
    i_EX_dMemWe  = dmemwe;
    i_EX_sWD     = swd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One single-cycle ALU transaction: present, clock into EX, check result.
  task automatic alu_txn(input string tag, input logic [3:0] op, input logic [31:0] rd1,
                         input logic [31:0] b, input logic use_imm, input logic [31:0] exp);
    drive(1'b1, op, 5'd3, rd1, use_imm ? 32'h0 : b, use_imm ? b : 32'h0, use_imm, 1'b1, 1'b0, 1'b0);
    step();
    $display("txn %s op=%0d aluOut=%h regWe=%0b stall=%0b", tag, op, o_EX_aluOut, o_EX_regWe, o_EX_stall);
    chk({tag, "_aluOut"}, o_EX_aluOut, exp);
    chk({tag, "_stall"}, {31'b0, o_EX_stall}, 32'd0);
  endtask

`ifdef EX_MULDIV_EN
  // Multi-cycle transaction; ID holds the instruction while stalled. Returns in the result beat.
  task automatic md_txn(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int n;
    bit bubble_ok;
    bit done;
    n = 0;
    bubble_ok = 1'b1;
    done = 1'b0;
    drive(1'b1, op, 5'd9, a, b, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 100 && !done; i++) begin
      step();
      if (o_EX_stall) begin
        n++;
        if (o_EX_regWe || o_EX_dMemWe || o_EX_sWD || (o_EX_WRA != 5'd0) || (o_EX_aluOut != 32'd0))
          bubble_ok = 1'b0;
      end else begin
        done = 1'b1;
      end
    end
    $display("txn %s op=%0d stall_cycles=%0d aluOut=%h regWe=%0b", tag, op, n, o_EX_aluOut, o_EX_regWe);
    chk({tag, "_finished"}, {31'b0, done}, 32'd1);
    chk({tag, "_stall_cycles"}, n, 32'd33);
    chk({tag, "_bubbles"}, {31'b0, bubble_ok}, 32'd1);
    chk({tag, "_aluOut"}, o_EX_aluOut, exp);
    chk({tag, "_regWe"}, {31'b0, o_EX_regWe}, 32'd1);
    chk({tag, "_WRA"}, {27'b0, o_EX_WRA}, 32'd9);
  endtask
`endif

  initial begin
    rst = 1'b1;
    i_EX_flush = 1'b0;
    drive(1'b0, 4'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    $display("txn reset aluOut=%h regWe=%0b stall=%0b", o_EX_aluOut, o_EX_regWe, o_EX_stall);
    chk("reset_aluOut", o_EX_aluOut, 32'h0);
    chk("reset_regWe", {31'b0, o_EX_regWe}, 32'd0);
    chk("reset_dMemWe", {31'b0, o_EX_dMemWe}, 32'd0);
    chk("reset_stall", {31'b0, o_EX_stall}, 32'd0);
    rst = 1'b0;

    // Single-cycle ALU vectors
    alu_txn("add_wrap", ALU_ADD, 32'h7FFF_FFFF, 32'h1, 1'b1, 32'h8000_0000);
    chk("add_regWe", {31'b0, o_EX_regWe}, 32'd1);
    chk("add_WRA", {27'b0, o_EX_WRA}, 32'd3);
    alu_txn("sub", ALU_SUB, 32'd5, 32'd7, 1'b0, 32'hFFFF_FFFE);
    alu_txn("and", ALU_AND, 32'hF0F0_FF00, 32'h0FF0_F0F0, 1'b0, 32'h00F0_F000);
    alu_txn("or", ALU_OR, 32'hF000_000F, 32'h0000_FF00, 1'b1, 32'hF000_FF0F);
    alu_txn("xor", ALU_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 1'b0, 32'h5555_5555);
    alu_txn("slt_neg", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd1);
    alu_txn("slt_pos", ALU_SLT, 32'd1, 32'hFFFF_FFFF, 1'b0, 32'd0);
    alu_txn("sll", ALU_SLL, 32'd1, 32'd31, 1'b1, 32'h8000_0000);
    alu_txn("srl", ALU_SRL, 32'h8000_0000, 32'h24, 1'b1, 32'h0800_0000);
    alu_txn("sra", ALU_SRA, 32'h8000_0000, 32'd4, 1'b1, 32'hF800_0000);
    alu_txn("undef12", 4'd12, 32'd5, 32'd6, 1'b0, 32'h0);

    // Bubble masking: invalid slot never writes
    drive(1'b0, ALU_ADD, 5'd4, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    $display("txn bubble regWe=%0b dMemWe=%0b", o_EX_regWe, o_EX_dMemWe);
    chk("bubble_regWe", {31'b0, o_EX_regWe}, 32'd0);
    chk("bubble_dMemWe", {31'b0, o_EX_dMemWe}, 32'd0);

    // Store: address from ALU, data on rd2
    drive(1'b1, ALU_ADD, 5'd0, 32'h1000, 32'hDEAD_BEEF, 32'h10, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    $display("txn store addr=%h data=%h dMemWe=%0b", o_EX_aluOut, o_EX_rd2, o_EX_dMemWe);
    chk("store_addr", o_EX_aluOut, 32'h1010);
    chk("store_data", o_EX_rd2, 32'hDEAD_BEEF);
    chk("store_dMemWe", {31'b0, o_EX_dMemWe}, 32'd1);

    // Load: writeback selects memory data
    drive(1'b1, ALU_ADD, 5'd7, 32'h2000, 32'h0, 32'h4, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    $display("txn load sWD=%0b WRA=%0d", o_EX_sWD, o_EX_WRA);
    chk("load_sWD", {31'b0, o_EX_sWD}, 32'd1);

    // Flush of a single-cycle instruction
    drive(1'b1, ALU_ADD, 5'd8, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    i_EX_flush = 1'b1;
    step();
    i_EX_flush = 1'b0;
    $display("txn flush regWe=%0b WRA=%0d", o_EX_regWe, o_EX_WRA);
    chk("flush_regWe", {31'b0, o_EX_regWe}, 32'd0);
    chk("flush_dMemWe", {31'b0, o_EX_dMemWe}, 32'd0);
    chk("flush_WRA", {27'b0, o_EX_WRA}, 32'd0);

`ifdef EX_MULDIV_EN
    md_txn("mul_wrap", ALU_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
    md_txn("mul", ALU_MUL, 32'h0000_1234, 32'h0000_5678, 32'h0626_0060);
    md_txn("divu", ALU_DIVU, 32'd100, 32'd7, 32'd14);
    md_txn("remu", ALU_REMU, 32'd100, 32'd7, 32'd2);
    md_txn("divu_by0", ALU_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);
    md_txn("remu_by0", ALU_REMU, 32'd5, 32'd0, 32'd5);

    // Flush at BUSY iteration 10 of a MUL
    drive(1'b1, ALU_MUL, 5'd9, 32'd3, 32'd5, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (12) step();
    chk("mulflush_busy_stall", {31'b0, o_EX_stall}, 32'd1);
    i_EX_flush = 1'b1;
    step();
    i_EX_flush = 1'b0;
    $display("txn mul_flush stall=%0b regWe=%0b aluOut=%h", o_EX_stall, o_EX_regWe, o_EX_aluOut);
    chk("mulflush_stall", {31'b0, o_EX_stall}, 32'd0);
    chk("mulflush_regWe", {31'b0, o_EX_regWe}, 32'd0);
    chk("mulflush_aluOut", o_EX_aluOut, 32'd0);
    alu_txn("add_after_flush", ALU_ADD, 32'd3, 32'd4, 1'b0, 32'd7);
    chk("add_after_flush_regWe", {31'b0, o_EX_regWe}, 32'd1);

    // Asynchronous reset in the middle of a DIVU
    drive(1'b1, ALU_DIVU, 5'd9, 32'd100, 32'd7, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (5) step();
    chk("rstmid_busy_stall", {31'b0, o_EX_stall}, 32'd1);
    #2 rst = 1'b1;
    #1;
    $display("txn rst_mid stall=%0b aluOut=%h regWe=%0b", o_EX_stall, o_EX_aluOut, o_EX_regWe);
    chk("rstmid_stall", {31'b0, o_EX_stall}, 32'd0);
    chk("rstmid_aluOut", o_EX_aluOut, 32'd0);
    chk("rstmid_regWe", {31'b0, o_EX_regWe}, 32'd0);
    rst = 1'b0;
    alu_txn("add_after_rst", ALU_ADD, 32'd10, 32'd20, 1'b0, 32'd30);
    chk("add_after_rst_regWe", {31'b0, o_EX_regWe}, 32'd1);
    md_txn("divu_after_rst", ALU_DIVU, 32'd50, 32'd6, 32'd8);
`else
    // Without the mul/div unit these ops complete in one cycle with a zero result
    alu_txn("mul_off", ALU_MUL, 32'h0000_1234, 32'h0000_5678, 1'b0, 32'h0);
    chk("mul_off_regWe", {31'b0, o_EX_regWe}, 32'd1);
    alu_txn("divu_off", ALU_DIVU, 32'd100, 32'd7, 1'b0, 32'h0);
    alu_txn("remu_off", ALU_REMU, 32'd100, 32'd7, 1'b0, 32'h0);
    alu_txn("add_after_off", ALU_ADD, 32'd10, 32'd20, 1'b0, 32'd30);
`endif

    drive(1'b0, 4'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
